patch_dispatcher: RTL and testbench

Sits upstream and downstream of a bank of `N_REDUCER` patch reducers and drives the other end of their handshakes. It takes patch start rows from a request stream, issues `init`/`start_row` to a free reducer in round-robin order, and collects finished sums with `sum_ack`. Each result goes out on a single valid/ack port, tagged with its start row. Results may leave out of request order.

---
 rtl/patch_dispatcher.sv | 169 ++++++++++++++++
 tb/tb_patch_dispatcher.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/patch_dispatcher.sv
// patch_dispatcher: hands patch start rows to a bank of reducers round-robin and collects their sums onto one result port.
// Optional PATCH_DISPATCHER_STATS_EN adds dispatch/collect counters and a stall pulse.
module patch_dispatcher #(
   parameter int N_ROW_SIZE = 1,
   parameter int FP_SIZE    = 1,
   parameter int N_REDUCER  = 4,
   localparam int PW        = $clog2(N_REDUCER),
   localparam int CW        = $clog2(N_REDUCER + 1)
) (
   input  logic                            dram_clk,
   input  logic                            reset_n,
   input  logic                            patch_valid,
   input  logic [N_ROW_SIZE-1:0]           patch_row,
   output logic                            patch_ack,
   input  logic [N_REDUCER-1:0]            red_available,
   output logic [N_REDUCER-1:0]            red_init,
   output logic [N_ROW_SIZE-1:0]           red_start_row,
   input  logic [N_REDUCER*N_ROW_SIZE-1:0] red_current_row,
   input  logic [N_REDUCER-1:0]            red_sum_rdy,
   input  logic [N_REDUCER*FP_SIZE-1:0]    red_sum,
   output logic [N_REDUCER-1:0]            red_sum_ack,
   output logic                            result_valid,
   output logic [N_ROW_SIZE-1:0]           result_row,
   output logic [FP_SIZE-1:0]              result_sum,
   input  logic                            result_ack,
`ifdef PATCH_DISPATCHER_STATS_EN
   output logic [31:0]                     stat_dispatched,
   output logic [31:0]                     stat_collected,
   output logic                            stat_stall,
`endif
   output logic [CW-1:0]                   n_in_flight
);

   localparam logic [N_REDUCER-1:0] ONE_HOT_LSB = N_REDUCER'(1);
   localparam logic [PW-1:0]        LAST_IDX    = PW'(N_REDUCER - 1);

   logic [N_REDUCER-1:0]  disp_elig;
   logic [N_REDUCER-1:0]  coll_elig;
   logic [PW-1:0]         disp_ptr;
   logic [PW-1:0]         coll_ptr;
   logic [PW-1:0]         disp_grant;
   logic [PW-1:0]         coll_grant;
   logic [PW-1:0]         disp_idx;
   logic [PW-1:0]         coll_idx;
   logic                  disp_any;
   logic                  coll_any;
   logic                  capture_ok;
   logic                  coll_fire;
   logic [N_ROW_SIZE-1:0] coll_row;
   logic [FP_SIZE-1:0]    coll_sum;
   logic [CW-1:0]         nif_next;

   // A reducer's available/sum_rdy only drops one cycle after it sees our pulse, so mask it meanwhile.
   assign disp_elig = red_available & ~red_init;
   assign coll_elig = red_sum_rdy & ~red_sum_ack;

   always_comb begin
      disp_any   = 1'b0;
      disp_grant = '0;
      disp_idx   = '0;
      for (int k = 0; k < N_REDUCER; k++) begin
         disp_idx = PW'((int'(disp_ptr) + k) % N_REDUCER);
         if (!disp_any && disp_elig[disp_idx]) begin
            disp_any   = 1'b1;
            disp_grant = disp_idx;
         end
      end
   end

   always_comb begin
      coll_any   = 1'b0;
      coll_grant = '0;
      coll_idx   = '0;
      for (int k = 0; k < N_REDUCER; k++) begin
         coll_idx = PW'((int'(coll_ptr) + k) % N_REDUCER);
         if (!coll_any && coll_elig[coll_idx]) begin
            coll_any   = 1'b1;
            coll_grant = coll_idx;
         end
      end
   end

   always_comb begin
      coll_row = '0;
      coll_sum = '0;
      for (int i = 0; i < N_REDUCER; i++) begin
         if (coll_grant == PW'(i)) begin
            coll_row = red_current_row[i*N_ROW_SIZE +: N_ROW_SIZE];
            coll_sum = red_sum[i*FP_SIZE +: FP_SIZE];
         end
      end
   end

   // Gated by reset so every output reads 0 the moment reset asserts.
   assign patch_ack  = reset_n && patch_valid && disp_any;
   assign capture_ok = !result_valid || result_ack;
   assign coll_fire  = capture_ok && coll_any;

   always_ff @(posedge dram_clk or negedge reset_n) begin
      if (!reset_n) begin
         red_init      <= '0;
         red_start_row <= '0;
         disp_ptr      <= '0;
      end else if (patch_ack) begin
         red_init      <= ONE_HOT_LSB << disp_grant;
         red_start_row <= patch_row;
         disp_ptr      <= (disp_grant == LAST_IDX) ? '0 : disp_grant + PW'(1);
      end else begin
         red_init      <= '0;
      end
   end

   always_ff @(posedge dram_clk or negedge reset_n) begin
      if (!reset_n) begin
         red_sum_ack  <= '0;
         result_valid <= 1'b0;
         result_row   <= '0;
         result_sum   <= '0;
         coll_ptr     <= '0;
      end else if (coll_fire) begin
         red_sum_ack  <= ONE_HOT_LSB << coll_grant;
         result_valid <= 1'b1;
         result_row   <= coll_row;
         result_sum   <= coll_sum;
         coll_ptr     <= (coll_grant == LAST_IDX) ? '0 : coll_grant + PW'(1);
      end else begin
         red_sum_ack  <= '0;
         if (result_ack) begin
            result_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      nif_next = n_in_flight;
      if (patch_ack && !coll_fire && n_in_flight != CW'(N_REDUCER)) begin
         nif_next = n_in_flight + CW'(1);
      end else if (coll_fire && !patch_ack && n_in_flight != '0) begin
         nif_next = n_in_flight - CW'(1);
      end
   end

   always_ff @(posedge dram_clk or negedge reset_n) begin
      if (!reset_n) begin
         n_in_flight <= '0;
      end else begin
         n_in_flight <= nif_next;
      end
   end

`ifdef PATCH_DISPATCHER_STATS_EN
   assign stat_stall = reset_n && patch_valid && !patch_ack;

   always_ff @(posedge dram_clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_dispatched <= '0;
         stat_collected  <= '0;
      end else begin
         if (patch_ack) begin
            stat_dispatched <= stat_dispatched + 32'd1;
         end
         if (coll_fire) begin
            stat_collected <= stat_collected + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_patch_dispatcher.sv
// Randomised bench for patch_dispatcher: behavioural reducer bank plus a cycle-level reference of the dispatch/collect rules.
`timescale 1ns/1ps
module tb_patch_dispatcher;
   localparam int NR = 8;
   localparam int FW = 32;
   localparam int N  = 4;
   localparam int CW = 3;

   logic            dram_clk = 1'b0;
   logic            reset_n  = 1'b0;
   logic            patch_valid;
   logic [NR-1:0]   patch_row;
   logic            patch_ack;
   logic [N-1:0]    red_available;
   logic [N-1:0]    red_init;
   logic [NR-1:0]   red_start_row;
   logic [N*NR-1:0] red_current_row;
   logic [N-1:0]    red_sum_rdy;
   logic [N*FW-1:0] red_sum;
   logic [N-1:0]    red_sum_ack;
   logic            result_valid;
   logic [NR-1:0]   result_row;
   logic [FW-1:0]   result_sum;
   logic            result_ack;
   logic [CW-1:0]   n_in_flight;

   always #5 dram_clk = ~dram_clk;

   patch_dispatcher #(.N_ROW_SIZE(NR), .FP_SIZE(FW), .N_REDUCER(N)) dut (
      .dram_clk(dram_clk), .reset_n(reset_n),
      .patch_valid(patch_valid), .patch_row(patch_row), .patch_ack(patch_ack),
      .red_available(red_available), .red_init(red_init), .red_start_row(red_start_row),
      .red_current_row(red_current_row), .red_sum_rdy(red_sum_rdy), .red_sum(red_sum),
      .red_sum_ack(red_sum_ack), .result_valid(result_valid), .result_row(result_row),
      .result_sum(result_sum), .result_ack(result_ack), .n_in_flight(n_in_flight)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reducer bank: 0 idle/available, 1 working, 2 holding a sum.
   int            r_state [N];
   int            r_cnt   [N];
   logic [NR-1:0] r_row   [N];
   logic [FW-1:0] r_sum   [N];
   int            lat_lo = 1, lat_hi = 4;
   int            lag_init, lag_ack;
   logic [NR-1:0] lag_row;

   // Reference: which reducer got a pulse last edge (-1 none), pointers, output register contents.
   int            m_init, m_sack, m_dptr, m_cptr, m_nif;
   logic [NR-1:0] m_srow, m_rrow;
   logic [FW-1:0] m_rsum;
   bit            m_rv;
   bit            last_ack;

   function automatic int rr_pick(input logic [N-1:0] elig, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (elig[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   task automatic drive_env();
      for (int i = 0; i < N; i++) begin
         red_available[i]            = (r_state[i] == 0);
         red_sum_rdy[i]              = (r_state[i] == 2);
         red_current_row[i*NR +: NR] = r_row[i];
         red_sum[i*FW +: FW]         = r_sum[i];
      end
   endtask

   task automatic env_reset();
      for (int i = 0; i < N; i++) begin
         r_state[i] = 0; r_cnt[i] = 0; r_row[i] = '0; r_sum[i] = '0;
      end
      lag_init = -1; lag_ack = -1; lag_row = '0;
      drive_env();
   endtask

   task automatic model_reset();
      m_init = -1; m_sack = -1; m_dptr = 0; m_cptr = 0; m_nif = 0;
      m_srow = '0; m_rrow = '0; m_rsum = '0; m_rv = 1'b0;
   endtask

   // Reducers react to a pulse one edge after it appears, as real reducers do.
   task automatic env_tick();
      for (int i = 0; i < N; i++) begin
         if (r_state[i] == 1) begin
            r_cnt[i]--;
            if (r_cnt[i] == 0) begin
               r_state[i] = 2;
               r_sum[i]   = $urandom;
            end
         end
      end
      if (lag_ack >= 0) r_state[lag_ack] = 0;
      if (lag_init >= 0) begin
         r_state[lag_init] = 1;
         r_cnt[lag_init]   = $urandom_range(lat_hi, lat_lo);
         r_row[lag_init]   = lag_row;
      end
      lag_init = m_init; lag_ack = m_sack; lag_row = m_srow;
      drive_env();
   endtask

   task automatic step();
      logic [N-1:0] de, ce;
      int g, c;
      bit ea, cap;
      env_tick();
      @(negedge dram_clk);
      for (int i = 0; i < N; i++) begin
         de[i] = (r_state[i] == 0) && (i != m_init);
         ce[i] = (r_state[i] == 2) && (i != m_sack);
      end
      g   = rr_pick(de, m_dptr);
      c   = rr_pick(ce, m_cptr);
      ea  = patch_valid && (g >= 0);
      cap = (!m_rv || result_ack) && (c >= 0);
      last_ack = patch_ack;
      chk("patch_ack", 64'(patch_ack), 64'(ea));
      m_init = ea ? g : -1;
      if (ea) begin
         m_srow = patch_row;
         m_dptr = (g + 1) % N;
      end
      if (cap) begin
         m_sack = c; m_rv = 1'b1; m_rrow = r_row[c]; m_rsum = r_sum[c];
         m_cptr = (c + 1) % N;
      end else begin
         m_sack = -1;
         if (result_ack) m_rv = 1'b0;
      end
      m_nif = m_nif + int'(ea) - int'(cap);
      @(posedge dram_clk);
      #1;
      chk("red_init",      64'(red_init),      64'(onehot(m_init)));
      chk("red_start_row", 64'(red_start_row), 64'(m_srow));
      chk("red_sum_ack",   64'(red_sum_ack),   64'(onehot(m_sack)));
      chk("result_valid",  64'(result_valid),  64'(m_rv));
      chk("result_row",    64'(result_row),    64'(m_rrow));
      chk("result_sum",    64'(result_sum),    64'(m_rsum));
      chk("n_in_flight",   64'(n_in_flight),   64'(m_nif));
   endtask

   task automatic chk_zero(input string pre);
      chk({pre, "_patch_ack"},    64'(patch_ack),     64'd0);
      chk({pre, "_red_init"},     64'(red_init),      64'd0);
      chk({pre, "_start_row"},    64'(red_start_row), 64'd0);
      chk({pre, "_sum_ack"},      64'(red_sum_ack),   64'd0);
      chk({pre, "_result_valid"}, 64'(result_valid),  64'd0);
      chk({pre, "_result_row"},   64'(result_row),    64'd0);
      chk({pre, "_result_sum"},   64'(result_sum),    64'd0);
      chk({pre, "_n_in_flight"},  64'(n_in_flight),   64'd0);
   endtask

   // Asserted between edges: outputs must clear with no clock edge.
   task automatic mid_reset();
      #2 reset_n = 1'b0;
      env_reset();
      model_reset();
      patch_valid = 1'b1;
      #1;
      chk_zero("rst_async");
      patch_valid = 1'b0;
      result_ack  = 1'b0;
      repeat (2) @(posedge dram_clk);
      #2 reset_n = 1'b1;
      #1;
      chk("rst_release_nif", 64'(n_in_flight), 64'd0);
   endtask

   task automatic random_phase(input int cycles, input int lo, input int hi,
                               input int valid_pct, input int ack_pct, input int reset_at);
      lat_lo = lo; lat_hi = hi;
      for (int n = 0; n < cycles; n++) begin
         if (n == reset_at) mid_reset();
         patch_valid = ($urandom_range(99, 0) < valid_pct);
         patch_row   = NR'($urandom_range(255, 0));
         result_ack  = ($urandom_range(99, 0) < ack_pct);
         step();
      end
   endtask

   initial begin
      patch_valid = 1'b0;
      patch_row   = '0;
      result_ack  = 1'b0;
      env_reset();
      model_reset();
      repeat (2) @(posedge dram_clk);
      #1;
      chk_zero("reset");
      reset_n = 1'b1;

      // Four back-to-back dispatches with every reducer free.
      lat_lo = 30; lat_hi = 30;
      result_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         patch_valid = 1'b1;
         patch_row   = NR'(10 + k);
         step();
         chk("dir_init_onehot", 64'(red_init), 64'(4'b0001 << k));
         chk("dir_start_row",   64'(red_start_row), 64'(10 + k));
      end
      chk("dir_nif_full", 64'(n_in_flight), 64'd4);

      // All reducers busy: request must stall until one finishes and is collected.
      for (int k = 0; k < 40; k++) begin
         patch_valid = 1'b1;
         patch_row   = NR'(20 + k);
         step();
         if (k >= 2 && k < 20) chk("busy_no_ack", 64'(last_ack), 64'd0);
      end

      random_phase(1000, 1, 3, 80, 90, -1);
      random_phase(1000, 1, 10, 60, 30, 500);
      random_phase(1000, 1, 2, 100, 100, -1);
      random_phase(600, 3, 8, 90, 5, 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
